// File: rtl/hs_dpath_pkg.sv
// Shared helpers for the hs_dpath blocks: counter and pointer width rules.
package hs_dpath_pkg;

  function automatic int hs_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int hs_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hs_dpath_wrap_cnt.sv
// Modulo-DEPTH pointer; advances on inc_i and wraps DEPTH-1 -> 0 for any DEPTH.
module hs_dpath_wrap_cnt
  import hs_dpath_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = hs_ptr_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/hs_dpath_crd_fifo.sv
// Credit-reserving output FIFO behind a fixed-latency, non-stallable pipeline.
// Issue slots are granted only while a storage entry is guaranteed.
module hs_dpath_crd_fifo
  import hs_dpath_pkg::*;
#(
  parameter  type      DATA_TYPE   = logic,
  parameter  DATA_TYPE RESET_VALUE = DATA_TYPE'(0),
  parameter  int       DEPTH       = 4,
  localparam int       CW          = hs_cnt_width(DEPTH),
  localparam int       PW          = hs_ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          issue_vld,
  output logic          issue_rdy,
  input  logic          din_vld,
  input  DATA_TYPE      din,
  output logic          dout_vld,
  output DATA_TYPE      dout,
  input  logic          dout_rdy,
  output logic [CW-1:0] occupancy,
  output logic          ovf_err
);

  logic [CW-1:0] reserved_q, reserved_d;
  logic [CW-1:0] stored_q, stored_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr, rd_ptr;
  DATA_TYPE      mem_q [DEPTH];

  logic issue, pop, full, push;

  assign issue = issue_vld && issue_rdy;
  assign pop   = dout_vld && dout_rdy;
  assign full  = (stored_q == CW'(DEPTH));
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push  = din_vld && (!full || pop);

  always_comb begin
    reserved_d = reserved_q;
    stored_d   = stored_q;
    ovf_d      = ovf_q | (din_vld && full && !pop);
    if (issue && !pop) begin
      reserved_d = reserved_q + CW'(1);
    end else if (pop && !issue && (reserved_q != '0)) begin
      reserved_d = reserved_q - CW'(1);
    end
    if (push && !pop) begin
      stored_d = stored_q + CW'(1);
    end else if (pop && !push) begin
      stored_d = stored_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      reserved_q <= '0;
      stored_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      reserved_q <= reserved_d;
      stored_q   <= stored_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VALUE;
    end else if (push) begin
      mem_q[wr_ptr] <= din;
    end
  end

  hs_dpath_wrap_cnt #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i  (clk),
    .rst_ni (aresetn),
    .inc_i  (push),
    .ptr_o  (wr_ptr)
  );

  hs_dpath_wrap_cnt #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i  (clk),
    .rst_ni (aresetn),
    .inc_i  (pop),
    .ptr_o  (rd_ptr)
  );

  assign issue_rdy = (reserved_q != CW'(DEPTH));
  assign dout_vld  = (stored_q != '0);
  assign dout      = mem_q[rd_ptr];
  assign occupancy = stored_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_hs_dpath_crd_fifo.sv
// Directed bench: three FIFO instances (DEPTH 5, 4, 3), each fed by a 3-stage shift-register pipeline.
module tb_hs_dpath_crd_fifo;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       issueVld  [3];
  logic [7:0] issueData [3];
  logic       issueRdy  [3];
  logic       dinVld    [3];
  logic [7:0] din       [3];
  logic       doutVld   [3];
  logic [7:0] dout      [3];
  logic       doutRdy   [3];
  logic       ovfErr    [3];
  logic       forceVld  [3];
  logic [7:0] forceData;
  logic [2:0] occ5, occ4;
  logic [1:0] occ3;

  logic [2:0] pv [3];
  logic [7:0] pd [3][3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Upstream pipeline, latency 3, reset together with the FIFOs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < 3; k++) begin
        pv[k] <= '0;
        for (int s = 0; s < 3; s++) pd[k][s] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        pv[k]    <= {pv[k][1:0], issueVld[k] & issueRdy[k]};
        pd[k][0] <= issueData[k];
        pd[k][1] <= pd[k][0];
        pd[k][2] <= pd[k][1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      dinVld[k] = pv[k][2] | forceVld[k];
      din[k]    = forceVld[k] ? forceData : pd[k][2];
    end
  end

  hs_dpath_crd_fifo #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'hA5), .DEPTH(5)) u_d5 (
    .clk(clk), .aresetn(aresetn), .issue_vld(issueVld[0]), .issue_rdy(issueRdy[0]),
    .din_vld(dinVld[0]), .din(din[0]), .dout_vld(doutVld[0]), .dout(dout[0]),
    .dout_rdy(doutRdy[0]), .occupancy(occ5), .ovf_err(ovfErr[0]));

  hs_dpath_crd_fifo #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'hA5), .DEPTH(4)) u_d4 (
    .clk(clk), .aresetn(aresetn), .issue_vld(issueVld[1]), .issue_rdy(issueRdy[1]),
    .din_vld(dinVld[1]), .din(din[1]), .dout_vld(doutVld[1]), .dout(dout[1]),
    .dout_rdy(doutRdy[1]), .occupancy(occ4), .ovf_err(ovfErr[1]));

  hs_dpath_crd_fifo #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'hA5), .DEPTH(3)) u_d3 (
    .clk(clk), .aresetn(aresetn), .issue_vld(issueVld[2]), .issue_rdy(issueRdy[2]),
    .din_vld(dinVld[2]), .din(din[2]), .dout_vld(doutVld[2]), .dout(dout[2]),
    .dout_rdy(doutRdy[2]), .occupancy(occ3), .ovf_err(ovfErr[2]));

  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] occOf(input int k);
    case (k)
      0:       return 32'(occ5);
      1:       return 32'(occ4);
      default: return 32'(occ3);
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the directed sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int tx, rx, first, acc, occM;
    logic pushM, popM;

    aresetn   = 1'b0;
    forceData = 8'h00;
    for (int k = 0; k < 3; k++) begin
      issueVld[k] = 1'b0; issueData[k] = 8'h00; doutRdy[k] = 1'b0; forceVld[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    applyStimulus();

    $display("[TB] reset state");
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset_issue_rdy%0d", k), 32'(issueRdy[k]), 32'd1);
      checkOutput($sformatf("reset_dout_vld%0d", k), 32'(doutVld[k]), 32'd0);
      checkOutput($sformatf("reset_occ%0d", k), occOf(k), 32'd0);
      checkOutput($sformatf("reset_ovf%0d", k), 32'(ovfErr[k]), 32'd0);
      checkOutput($sformatf("reset_dout%0d", k), 32'(dout[k]), 32'hA5);
    end

    $display("[TB] streaming DEPTH=5");
    tx = 0; rx = 0; first = -1;
    doutRdy[0] = 1'b1;
    for (int c = 0; c < 100 && rx < 32; c++) begin
      if (tx < 32) checkOutput("stream_issue_rdy", 32'(issueRdy[0]), 32'd1);
      issueVld[0]  = (tx < 32);
      issueData[0] = 8'(tx + 1);
      if (issueVld[0] && issueRdy[0]) tx++;
      applyStimulus();
      if (doutVld[0]) begin
        if (first < 0) first = c + 1;
        checkOutput("stream_data", 32'(dout[0]), 32'(rx + 1));
        rx++;
      end
    end
    issueVld[0] = 1'b0;
    checkOutput("stream_count", 32'(rx), 32'd32);
    checkOutput("stream_first_latency", 32'(first), 32'd4);
    applyStimulus();
    checkOutput("stream_drained_occ", 32'(occ5), 32'd0);
    doutRdy[0] = 1'b0;

    $display("[TB] backpressure DEPTH=4");
    acc = 0;
    issueVld[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      issueData[1] = 8'(8'h10 + acc);
      if (issueVld[1] && issueRdy[1]) acc++;
      applyStimulus();
    end
    checkOutput("bp_accepted", 32'(acc), 32'd4);
    checkOutput("bp_issue_rdy_low", 32'(issueRdy[1]), 32'd0);
    checkOutput("bp_occ_full", 32'(occ4), 32'd4);
    checkOutput("bp_ovf", 32'(ovfErr[1]), 32'd0);
    checkOutput("bp_head", 32'(dout[1]), 32'h10);
    doutRdy[1] = 1'b1;
    applyStimulus();
    doutRdy[1] = 1'b0;
    issueVld[1] = 1'b0;
    checkOutput("bp_issue_rdy_recover", 32'(issueRdy[1]), 32'd1);
    checkOutput("bp_occ_after_pop", 32'(occ4), 32'd3);
    checkOutput("bp_head_after_pop", 32'(dout[1]), 32'h11);
    doutRdy[1] = 1'b1;
    applyStimulus();
    checkOutput("bp_drain1", 32'(dout[1]), 32'h12);
    applyStimulus();
    checkOutput("bp_drain2", 32'(dout[1]), 32'h13);
    applyStimulus();
    checkOutput("bp_drained_vld", 32'(doutVld[1]), 32'd0);
    doutRdy[1] = 1'b0;

    $display("[TB] wrap DEPTH=3");
    tx = 0; rx = 0; occM = 0;
    for (int c = 0; c < 200 && rx < 10; c++) begin
      issueVld[2]  = (tx < 10);
      issueData[2] = 8'(8'h30 + tx);
      doutRdy[2]   = 1'($urandom_range(0, 1));
      if (issueVld[2] && issueRdy[2]) tx++;
      pushM = dinVld[2];
      popM  = doutVld[2] && doutRdy[2];
      if (popM) begin
        checkOutput("wrap_order", 32'(dout[2]), 32'(8'h30 + rx));
        rx++;
      end
      occM = occM + int'(pushM) - int'(popM);
      applyStimulus();
      checkOutput("wrap_occ", 32'(occ3), 32'(occM));
    end
    issueVld[2] = 1'b0;
    doutRdy[2]  = 1'b0;
    checkOutput("wrap_count", 32'(rx), 32'd10);

    $display("[TB] overflow DEPTH=3");
    tx = 0;
    for (int c = 0; c < 10; c++) begin
      issueVld[2]  = (tx < 3);
      issueData[2] = 8'(8'h40 + tx);
      if (issueVld[2] && issueRdy[2]) tx++;
      applyStimulus();
    end
    issueVld[2] = 1'b0;
    checkOutput("ovf_setup_occ", 32'(occ3), 32'd3);
    checkOutput("ovf_setup_rdy", 32'(issueRdy[2]), 32'd0);
    forceVld[2] = 1'b1; forceData = 8'hEE;
    applyStimulus();
    forceVld[2] = 1'b0;
    checkOutput("ovf_occ_held", 32'(occ3), 32'd3);
    checkOutput("ovf_flag", 32'(ovfErr[2]), 32'd1);
    checkOutput("ovf_head_kept", 32'(dout[2]), 32'h40);
    forceVld[2] = 1'b1; forceData = 8'h77; doutRdy[2] = 1'b1;
    applyStimulus();
    forceVld[2] = 1'b0;
    checkOutput("full_pushpop_occ", 32'(occ3), 32'd3);
    checkOutput("full_pushpop_head", 32'(dout[2]), 32'h41);
    applyStimulus();
    checkOutput("ovf_drain1", 32'(dout[2]), 32'h42);
    applyStimulus();
    checkOutput("ovf_drain2", 32'(dout[2]), 32'h77);
    applyStimulus();
    doutRdy[2] = 1'b0;
    checkOutput("ovf_drained_vld", 32'(doutVld[2]), 32'd0);
    checkOutput("ovf_sticky", 32'(ovfErr[2]), 32'd1);

    $display("[TB] reset mid-stream DEPTH=5");
    issueVld[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      issueData[0] = 8'(8'h51 + c);
      applyStimulus();
    end
    issueVld[0] = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("mid_occ_before", 32'(occ5), 32'd2);
    checkOutput("mid_head_before", 32'(dout[0]), 32'h51);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("mid_rst_issue_rdy", 32'(issueRdy[0]), 32'd1);
    checkOutput("mid_rst_dout_vld", 32'(doutVld[0]), 32'd0);
    checkOutput("mid_rst_occ", 32'(occ5), 32'd0);
    checkOutput("mid_rst_dout", 32'(dout[0]), 32'hA5);
    checkOutput("mid_rst_ovf_d3", 32'(ovfErr[2]), 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    issueVld[0] = 1'b1; issueData[0] = 8'h61; doutRdy[0] = 1'b1;
    applyStimulus();
    issueVld[0] = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("post_rst_not_yet", 32'(doutVld[0]), 32'd0);
    applyStimulus();
    checkOutput("post_rst_vld", 32'(doutVld[0]), 32'd1);
    checkOutput("post_rst_data", 32'(dout[0]), 32'h61);
    applyStimulus();
    checkOutput("post_rst_empty", 32'(doutVld[0]), 32'd0);
    checkOutput("post_rst_occ", 32'(occ5), 32'd0);
    checkOutput("post_rst_issue_rdy", 32'(issueRdy[0]), 32'd1);
    doutRdy[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
